// File: rtl/iiitb_pgc_pkg.sv
// iiitb_gc_pkg: Gray/binary conversion helpers and width limits for the iiitb_pgc counter.
// Functions work on MAX_WIDTH-bit vectors; callers zero-extend and truncate to their own width.
package iiitb_gc_pkg;
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/iiitb_pgc_if.sv
// iiitb_pgc_if: control and status bundle of the Gray counter.
// master drives enable/up/sat/clear/load/load_gray and observes gray_count/wrap/at_limit
// (plus bin_count when IIITB_PGC_BIN_OUT_EN is defined); slave is the counter side.
interface iiitb_pgc_if #(parameter int WIDTH = 8);
    logic             enable;
    logic             up;
    logic             sat;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray_count;
    logic             wrap;
    logic             at_limit;
`ifdef IIITB_PGC_BIN_OUT_EN
    logic [WIDTH-1:0] bin_count;
    modport master (output enable, up, sat, clear, load, load_gray, input gray_count, wrap, at_limit, bin_count);
    modport slave (input enable, up, sat, clear, load, load_gray, output gray_count, wrap, at_limit, bin_count);
`else
    modport master (output enable, up, sat, clear, load, load_gray, input gray_count, wrap, at_limit);
    modport slave (input enable, up, sat, clear, load, load_gray, output gray_count, wrap, at_limit);
`endif
endinterface

// File: rtl/iiitb_pgc_gray2bin.sv
// iiitb_gray2bin: combinational WIDTH-bit Gray-to-binary converter.
// Ports: gray (in, WIDTH) Gray code; bin (out, WIDTH) matching binary value.
module iiitb_gray2bin #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // each binary bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/iiitb_pgc.sv
// iiitb_pgc: parametrised up/down Gray counter with clear, Gray load, wrap/saturate modes.
// Ports: clk, reset (async, active-high); bus (iiitb_pgc_if.slave) carrying enable, up, sat,
// clear, load, load_gray in and registered gray_count, wrap, at_limit out.
// IIITB_PGC_BIN_OUT_EN adds bus.bin_count, the binary value matching gray_count.
module iiitb_pgc
    import iiitb_gc_pkg::*;
#(parameter int WIDTH = 8) (
    input logic          clk,
    input logic          reset,
    iiitb_pgc_if.slave   bus
);
    localparam logic [WIDTH-1:0] TOP = '1;
    logic [WIDTH-1:0] bin, bin_nx, ld_bin, gray_q;
    logic             wrap_q, lim_q, wrap_nx, lim_nx, at_end;

    iiitb_gray2bin #(.WIDTH(WIDTH)) u_g2b (.gray(bus.load_gray), .bin(ld_bin));

    assign at_end = bus.up ? (bin == TOP) : (bin == '0);

    always_comb begin
        bin_nx  = bin;
        wrap_nx = 1'b0;
        lim_nx  = 1'b0;
        if (bus.clear) bin_nx = '0;
        else if (bus.load) bin_nx = ld_bin;
        else if (bus.enable) begin
            if (at_end && bus.sat) lim_nx = 1'b1;
            else begin
                // modulo arithmetic yields the wrap value at the terminal count
                bin_nx  = bus.up ? bin + 1'b1 : bin - 1'b1;
                wrap_nx = at_end;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin    <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            lim_q  <= 1'b0;
        end else begin
            bin    <= bin_nx;
            gray_q <= WIDTH'(bin2gray(MAX_WIDTH'(bin_nx)));
            wrap_q <= wrap_nx;
            lim_q  <= lim_nx;
        end
    end

    assign bus.gray_count = gray_q;
    assign bus.wrap       = wrap_q;
    assign bus.at_limit   = lim_q;
`ifdef IIITB_PGC_BIN_OUT_EN
    assign bus.bin_count  = bin;
`endif
endmodule

// File: tb/tb_iiitb_pgc.sv
// tb_iiitb_pgc: directed self-checking bench for iiitb_pgc at WIDTH=8.
module tb_iiitb_pgc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] prev;
    logic [7:0] seq [7] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};

    iiitb_pgc_if #(.WIDTH(8)) bus ();
    iiitb_pgc #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef IIITB_PGC_BIN_OUT_EN
        check("bin_match", {24'd0, bus.bin_count}, {24'd0, 8'(iiitb_gc_pkg::gray2bin(64'(bus.gray_count)))});
`endif
    endtask

    initial begin
        bus.enable = 0; bus.up = 1; bus.sat = 0; bus.clear = 0; bus.load = 0; bus.load_gray = 0;
        #3;
        check("rst_gray", {24'd0, bus.gray_count}, 0);
        check("rst_wrap", {31'd0, bus.wrap}, 0);
        check("rst_lim", {31'd0, bus.at_limit}, 0);
        tick();
        reset = 0;
        bus.enable = 1;
        check("seq0", {24'd0, bus.gray_count}, 32'h00);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("seq", {24'd0, bus.gray_count}, {24'd0, seq[i]});
        end
        for (int i = 0; i < 400; i++) begin
            prev = bus.gray_count;
            tick();
            check("one_bit", $countones(prev ^ bus.gray_count), 1);
        end
        // up wrap from bin 255
        bus.enable = 0; bus.load = 1; bus.load_gray = 8'h80;
        tick();
        check("ld80", {24'd0, bus.gray_count}, 32'h80);
        check("ld80_wrap", {31'd0, bus.wrap}, 0);
        bus.load = 0; bus.enable = 1; bus.up = 1; bus.sat = 0;
        tick();
        check("upwrap", {24'd0, bus.gray_count}, 32'h00);
        check("upwrap_w", {31'd0, bus.wrap}, 1);
        tick();
        check("after_wrap", {24'd0, bus.gray_count}, 32'h01);
        check("after_wrap_w", {31'd0, bus.wrap}, 0);
        // down wrap and saturate at zero
        bus.clear = 1;
        tick();
        check("clr", {24'd0, bus.gray_count}, 0);
        bus.clear = 0; bus.up = 0;
        tick();
        check("dnwrap", {24'd0, bus.gray_count}, 32'h80);
        check("dnwrap_w", {31'd0, bus.wrap}, 1);
        bus.clear = 1;
        tick();
        bus.clear = 0; bus.sat = 1;
        tick();
        check("sat0", {24'd0, bus.gray_count}, 0);
        check("sat0_lim", {31'd0, bus.at_limit}, 1);
        check("sat0_wrap", {31'd0, bus.wrap}, 0);
        tick();
        check("sat0_hold", {31'd0, bus.at_limit}, 1);
        bus.enable = 0;
        tick();
        check("lim_en0", {31'd0, bus.at_limit}, 0);
        bus.enable = 1;
        tick();
        check("lim_again", {31'd0, bus.at_limit}, 1);
        bus.up = 1;
        tick();
        check("rev_gray", {24'd0, bus.gray_count}, 32'h01);
        check("rev_lim", {31'd0, bus.at_limit}, 0);
        // load wins over enable; clear wins over load
        bus.load = 1; bus.load_gray = 8'hC0; bus.sat = 0;
        tick();
        check("ldC0", {24'd0, bus.gray_count}, 32'hC0);
        bus.load = 0;
        tick();
        check("ldC0_up", {24'd0, bus.gray_count}, 32'hC1);
        bus.clear = 1; bus.load = 1;
        tick();
        check("clr_ld", {24'd0, bus.gray_count}, 0);
        // saturate at top, then reverse
        bus.clear = 0; bus.load_gray = 8'h80;
        tick();
        bus.load = 0; bus.sat = 1;
        tick();
        check("sat_top", {24'd0, bus.gray_count}, 32'h80);
        check("sat_top_lim", {31'd0, bus.at_limit}, 1);
        bus.up = 0;
        tick();
        check("sat_top_rev", {24'd0, bus.gray_count}, 32'h81);
        check("sat_top_rev_lim", {31'd0, bus.at_limit}, 0);
        // async reset mid-count at 0x35
        bus.sat = 0; bus.up = 1; bus.load = 1; bus.load_gray = 8'h35;
        tick();
        check("ld35", {24'd0, bus.gray_count}, 32'h35);
        bus.load = 0;
        #2 reset = 1;
        #1;
        check("arst_gray", {24'd0, bus.gray_count}, 0);
        check("arst_wrap", {31'd0, bus.wrap}, 0);
        check("arst_lim", {31'd0, bus.at_limit}, 0);
        reset = 0;
        tick();
        check("post_rst", {24'd0, bus.gray_count}, 32'h01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
